// File: rtl/gate_bist_ctrl.sv
// Built-in self-test sequencer for the two-input basic-gate block: sweeps a/b
// through all four combinations, checks seven gate outputs, reports a verdict.
module gate_bist_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned PASSES        = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_and,
    input  logic       dut_or,
    input  logic       dut_not_a,
    input  logic       dut_nand,
    input  logic       dut_nor,
    input  logic       dut_xor,
    input  logic       dut_xnor,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] fail_vec,
    output logic [3:0] err_cnt,
    output logic [1:0] vec_idx
);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] PASS_LAST   = 4'(PASSES - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] settle_cnt;
    logic [3:0] pass_cnt;
    logic [6:0] sampled;
    logic [6:0] expected;
    logic [6:0] mismatch;
    logic [6:0] fail_upd;
    logic [2:0] mismatch_cnt;
    logic [4:0] err_sum;
    logic [3:0] err_sat;
    logic [1:0] vec_next;
    logic       last_vec;
    logic       in_run;
    logic       abort_run;

    always_comb begin
        sampled  = {dut_xnor, dut_xor, dut_nor, dut_nand, dut_not_a, dut_or, dut_and};
        expected = {~(dut_a ^ dut_b), dut_a ^ dut_b, ~(dut_a | dut_b), ~(dut_a & dut_b),
                    ~dut_a, dut_a | dut_b, dut_a & dut_b};
        mismatch = sampled ^ expected;
        fail_upd = fail_vec | mismatch;
        mismatch_cnt = 3'd0;
        for (int i = 0; i < 7; i++) begin
            mismatch_cnt = mismatch_cnt + {2'b00, mismatch[i]};
        end
        err_sum   = {1'b0, err_cnt} + {2'b00, mismatch_cnt};
        err_sat   = (err_sum > 5'd15) ? 4'hF : err_sum[3:0];
        vec_next  = vec_idx + 2'd1;
        last_vec  = (vec_idx == 2'd3) && (pass_cnt == PASS_LAST);
        in_run    = (state == APPLY) || (state == SETTLE) || (state == CHECK);
        abort_run = in_run && abort;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && !abort) state_next = APPLY;
            APPLY:   state_next = abort ? IDLE : SETTLE;
            SETTLE:  if (abort) state_next = IDLE;
                     else if (settle_cnt == 4'd0) state_next = CHECK;
            CHECK:   if (abort) state_next = IDLE;
                     else state_next = last_vec ? DONE : APPLY;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The gate drive is loaded as APPLY is entered so that it always matches
    // vec_idx for the whole vector; an aborted CHECK leaves the flags untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_vec   <= 7'd0;
            err_cnt    <= 4'd0;
            vec_idx    <= 2'd0;
            dut_a      <= 1'b0;
            dut_b      <= 1'b0;
            settle_cnt <= 4'd0;
            pass_cnt   <= 4'd0;
        end else begin
            busy <= (state_next == APPLY) || (state_next == SETTLE) || (state_next == CHECK);
            done <= (state_next == DONE);
            if (abort_run) begin
                dut_a   <= 1'b0;
                dut_b   <= 1'b0;
                vec_idx <= 2'd0;
                pass    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            fail_vec <= 7'd0;
                            err_cnt  <= 4'd0;
                            pass     <= 1'b0;
                            vec_idx  <= 2'd0;
                            pass_cnt <= 4'd0;
                            dut_a    <= 1'b0;
                            dut_b    <= 1'b0;
                        end
                    end
                    APPLY: settle_cnt <= SETTLE_LOAD;
                    SETTLE: begin
                        if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
                    end
                    CHECK: begin
                        fail_vec <= fail_upd;
                        err_cnt  <= err_sat;
                        if (last_vec) begin
                            pass <= (fail_upd == 7'd0);
                        end else begin
                            vec_idx <= vec_next;
                            dut_a   <= vec_next[1];
                            dut_b   <= vec_next[0];
                            if (vec_idx == 2'd3) pass_cnt <= pass_cnt + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/gate_bist_ctrl.md
# gate_bist_ctrl

Built-in self-test sequencer for the two-input basic-gate block. It drives the gate block's `a`/`b` inputs through all four input combinations, waits a programmable settle time and samples the seven gate outputs. Each sample is compared against an internally computed truth table. It reports per-gate sticky failure flags, a saturating mismatch count and a pass/fail verdict, and sits between the test/control logic and the gate block instance.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: wait cycles between driving a vector and sampling; legal 1..15.
- `PASSES`, default 1: full 4-vector sweeps per run; legal 1..15.

Ports (clock and reset first; one clock; reset is asynchronous and active-low):
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: level, sampled only in IDLE.
- `abort` in 1: level, terminates a run.
- `dut_a`, `dut_b` out 1 each: registered drive to gate block `a`, `b`.
- `dut_and`, `dut_or`, `dut_not_a`, `dut_nand`, `dut_nor`, `dut_xor`, `dut_xnor` in 1 each: gate block outputs.
- `busy` out 1: high in APPLY/SETTLE/CHECK.
- `done` out 1: one-cycle pulse at normal completion.
- `pass` out 1: verdict, valid from `done` until next accepted start.
- `fail_vec` out 7: sticky per-gate mismatch; bit order [0] and, [1] or, [2] not_a, [3] nand, [4] nor, [5] xor, [6] xnor.
- `err_cnt` out 4: saturating count of mismatching output bits.
- `vec_idx` out 2: current vector; `dut_a`=vec_idx[1], `dut_b`=vec_idx[0].

## Operation
- States: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE:
  - `start`=1 and `abort`=0 → APPLY.
  - On that transition: clear `fail_vec`, `err_cnt`, `pass`, `vec_idx` and the pass counter.
  - `abort` wins over simultaneous `start`: remain in IDLE.
- APPLY (1 cycle): `dut_a`/`dut_b` register from `vec_idx`; load settle counter with SETTLE_CYCLES-1 → SETTLE.
- SETTLE (SETTLE_CYCLES cycles): count down; at 0 → CHECK.
- CHECK (1 cycle):
  - Expected values: and=a&b, or=a|b, not_a=~a, nand=~(a&b), nor=~(a|b), xor=a^b, xnor=~(a^b), computed from the registered `dut_a`/`dut_b`.
  - mismatch[6:0] = sampled ^ expected.
  - `fail_vec` |= mismatch.
  - `err_cnt` = min(15, `err_cnt` + popcount(mismatch)).
  - If vec_idx==3 and pass counter==PASSES-1 → DONE.
  - Otherwise `vec_idx` increments, wrapping 3→0; the pass counter increments on wrap; → APPLY.
- DONE (1 cycle): `done`=1; `pass` registers (`fail_vec`==0 including this last CHECK's update); → IDLE. `start` is ignored in DONE.
- `abort`=1 in APPLY/SETTLE/CHECK:
  - → IDLE next cycle; no `done`; `pass`=0.
  - `fail_vec`/`err_cnt` keep their values as of the last completed CHECK; an aborted CHECK does not update them.
  - `dut_a`/`dut_b` return to 0 and `vec_idx` clears to 0.
- `start` while busy is ignored.

## Timing
- Reset values: state IDLE; `dut_a`, `dut_b`, `busy`, `done`, `pass`=0; `fail_vec`=0; `err_cnt`=0; `vec_idx`=0. Reset mid-run returns to IDLE immediately with these values.
- All outputs are registered; gate inputs are sampled only in CHECK.
- Per vector: SETTLE_CYCLES+2 cycles.
- `start` sampled at edge k → `busy` high from k+1, and `done` high in cycle k+1+4·PASSES·(SETTLE_CYCLES+2). With defaults, `done` is high 17 cycles after the start edge.
- `busy` and `done` are never high together.
- Earliest next run: `start` sampled in the cycle after `done`.

## Test plan
- Correct gate model, defaults, one `start` pulse → `done` 17 cycles after the start edge; `pass`=1, `fail_vec`=0, `err_cnt`=0; `dut_a`,`dut_b` sequence 00,01,10,11, each held 4 cycles.
- `dut_xor` stuck at 0 → mismatches at vectors 01 and 10; `fail_vec`=7'b0100000, `err_cnt`=2, `pass`=0.
- All seven outputs inverted, PASSES=3 → 84 raw mismatches; `err_cnt` saturates at 15, `fail_vec`=7'h7F, `pass`=0, `done` after 1+12·4=49 cycles.
- `abort` asserted during SETTLE of vector 2 → IDLE next cycle; no `done`; `busy`=0, `pass`=0, `dut_a`/`dut_b`=0, `vec_idx`=0; then a new `start` clears flags and runs to completion normally.
- `rst_n` low mid-CHECK → all outputs 0 asynchronously; `start` and `abort` together in IDLE → no run.
- `start` held high throughout → back-to-back runs: `done`, one IDLE cycle, then `busy`; `start` pulses while `busy` do not restart the run or alter its timing.
